elevator_scan_controller: RTL and testbench

//  Parametrised multi-floor elevator controller: latches hall/car calls into a pending mask.

---
 rtl/elevator_pkg.sv | 40 ++++
 rtl/elevator_tick_timer.sv | 35 +++
 rtl/elevator_scan_controller.sv | 151 +++++++++++++++
 tb/tb_elevator_scan_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state type and call-mask helpers for the SCAN elevator
// Contents:
//   state_t    : controller state (ST_IDLE, ST_MOVE, ST_DOOR)
//   MAX_FLOORS : width of the helper mask arguments (largest supported building)
//   FLOOR_W    : floor index width for a given floor count
//   any_above  : 1 when any mask bit lies strictly above floor
//   any_below  : 1 when any mask bit lies strictly below floor
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVE,
      ST_DOOR
   } state_t;

   localparam int MAX_FLOORS = 16;

   function automatic int FLOOR_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input int floor);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (i > floor && mask[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input int floor);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (i < floor && mask[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// rtl/elevator_tick_timer.sv - wrapping tick counter used for travel and door dwell
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   clear  in  force count to 0 (wins over en)
//   en     in  advance count; wraps to 0 after the terminal value
//   done   out count is at MAX-1 (terminal tick of the interval)
module elevator_tick_timer #(
   parameter int MAX = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic done
);

   localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] count;

   assign done = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= done ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/elevator_scan_controller.sv
// rtl/elevator_scan_controller.sv - SCAN-order elevator controller with travel and dwell timing
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   call_req       in   [NUM_FLOORS] call request per floor (pulse or level)
//   current_floor  out  [FW] floor the car is at / last passed
//   pending        out  [NUM_FLOORS] outstanding-call mask
//   dir_up         out  travel direction (held while stopped)
//   moving         out  car travelling between floors
//   door_open      out  door dwell in progress
//   idle           out  no work, car parked
module elevator_scan_controller
   import elevator_pkg::*;
#(
   parameter int  NUM_FLOORS = 9,
   parameter int  MOVE_TICKS = 10,
   parameter int  DOOR_TICKS = 20,
   localparam int FW         = FLOOR_W(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [FW-1:0]         current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up,
   output logic                  moving,
   output logic                  door_open,
   output logic                  idle
);

   localparam logic [FW-1:0]         TOP_FLOOR = FW'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] ONE       = NUM_FLOORS'(1);

   // {idle, moving, door_open} per state
   localparam logic [2:0] FL_IDLE = 3'b100;
   localparam logic [2:0] FL_MOVE = 3'b010;
   localparam logic [2:0] FL_DOOR = 3'b001;

   state_t                  state;
   logic [MAX_FLOORS-1:0]   pend_w;
   logic [NUM_FLOORS-1:0]   cur_oh;
   logic [NUM_FLOORS-1:0]   step_oh;
   logic [NUM_FLOORS-1:0]   pend_in;
   logic [FW-1:0]           step_floor;
   logic                    here_call;
   logic                    above_cur;
   logic                    below_cur;
   logic                    above_step;
   logic                    below_step;
   logic                    depart_up;
   logic                    move_done;
   logic                    door_done;

   assign pend_w    = MAX_FLOORS'(pending);
   assign cur_oh    = ONE << current_floor;
   assign step_oh   = ONE << step_floor;
   assign pend_in   = pending | call_req;
   assign here_call = |(call_req & cur_oh);

   // Floor reached at the end of the current travel interval; saturates at the shaft ends.
   assign step_floor = (dir_up && current_floor != TOP_FLOOR) ? current_floor + 1'b1 :
                       (!dir_up && current_floor != '0)       ? current_floor - 1'b1 :
                                                                current_floor;

   assign above_cur  = any_above(pend_w, int'(current_floor));
   assign below_cur  = any_below(pend_w, int'(current_floor));
   assign above_step = any_above(pend_w, int'(step_floor));
   assign below_step = any_below(pend_w, int'(step_floor));

   // Departure direction: keep the current heading when calls lie on both sides.
   assign depart_up = dir_up ? above_cur : !below_cur;

   elevator_tick_timer #(.MAX(MOVE_TICKS)) u_move_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state != ST_MOVE),
      .en    (state == ST_MOVE),
      .done  (move_done)
   );

   // A call for the landing floor while the door is open restarts the dwell.
   elevator_tick_timer #(.MAX(DOOR_TICKS)) u_door_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state != ST_DOOR || here_call),
      .en    (state == ST_DOOR),
      .done  (door_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                      <= ST_IDLE;
         current_floor              <= '0;
         pending                    <= '0;
         dir_up                     <= 1'b1;
         {idle, moving, door_open}  <= FL_IDLE;
      end else begin
         pending <= pend_in;
         case (state)
            ST_IDLE: begin
               // A call for the parked floor opens the door straight away and never
               // shows up in pending.
               if (here_call || (pending & cur_oh) != '0) begin
                  state                     <= ST_DOOR;
                  {idle, moving, door_open} <= FL_DOOR;
                  pending                   <= pend_in & ~cur_oh;
               end else if (above_cur || below_cur) begin
                  state                     <= ST_MOVE;
                  {idle, moving, door_open} <= FL_MOVE;
                  dir_up                    <= depart_up;
               end
            end
            ST_MOVE: begin
               if (move_done) begin
                  current_floor <= step_floor;
                  if ((pending & step_oh) != '0) begin
                     state                     <= ST_DOOR;
                     {idle, moving, door_open} <= FL_DOOR;
                     pending                   <= pend_in & ~step_oh;
                  end else if (!(dir_up ? above_step : below_step)) begin
                     if (dir_up ? below_step : above_step) begin
                        dir_up <= !dir_up;
                     end else begin
                        state                     <= ST_IDLE;
                        {idle, moving, door_open} <= FL_IDLE;
                     end
                  end
               end
            end
            ST_DOOR: begin
               pending <= pend_in & ~cur_oh;
               if (door_done && !here_call) begin
                  if (above_cur || below_cur) begin
                     state                     <= ST_MOVE;
                     {idle, moving, door_open} <= FL_MOVE;
                     dir_up                    <= depart_up;
                  end else begin
                     state                     <= ST_IDLE;
                     {idle, moving, door_open} <= FL_IDLE;
                  end
               end
            end
            default: begin
               state                     <= ST_IDLE;
               {idle, moving, door_open} <= FL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb/tb_elevator_scan_controller.sv - self-checking bench for elevator_scan_controller
module tb_elevator_scan_controller;

   localparam int NF = 9;
   localparam int MT = 10;
   localparam int DT = 20;

   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NF-1:0] call_req = '0;
   logic [3:0]    current_floor;
   logic [NF-1:0] pending;
   logic          dir_up, moving, door_open, idle;

   logic [15:0]   req16 = '0;
   logic [3:0]    f16;
   logic [15:0]   p16;
   logic          u16_dir, u16_mov, u16_door, u16_idle;

   logic [1:0]    req2 = '0;
   logic [0:0]    f2;
   logic [1:0]    p2;
   logic          u2_dir, u2_mov, u2_door, u2_idle;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   always #5 clk = ~clk;

   elevator_scan_controller #(.NUM_FLOORS(NF), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
      .clk(clk), .rst_n(rst_n), .call_req(call_req), .current_floor(current_floor),
      .pending(pending), .dir_up(dir_up), .moving(moving), .door_open(door_open), .idle(idle)
   );

   elevator_scan_controller #(.NUM_FLOORS(16), .MOVE_TICKS(3), .DOOR_TICKS(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .call_req(req16), .current_floor(f16),
      .pending(p16), .dir_up(u16_dir), .moving(u16_mov), .door_open(u16_door), .idle(u16_idle)
   );

   elevator_scan_controller #(.NUM_FLOORS(2), .MOVE_TICKS(3), .DOOR_TICKS(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .call_req(req2), .current_floor(f2),
      .pending(p2), .dir_up(u2_dir), .moving(u2_mov), .door_open(u2_door), .idle(u2_idle)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_mode  = M_IDLE;
   int          m_floor = 0;
   int          m_cnt   = 0;
   bit          m_dir   = 1'b1;
   int unsigned m_pend  = 0;

   function automatic bit has_bit(input int unsigned m, input int f);
      return ((m >> f) & 1) != 0;
   endfunction

   function automatic bit has_above(input int unsigned m, input int f);
      return (m >> (f + 1)) != 0;
   endfunction

   function automatic bit has_below(input int unsigned m, input int f);
      return (m & ((32'd1 << f) - 1)) != 0;
   endfunction

   task automatic model_step(input int unsigned r);
      int  nf, nmode, ncnt;
      bit  nd, up_calls, down_calls, go_up, ahead, behind;
      int unsigned npend;
      nf         = m_floor;
      nmode      = m_mode;
      ncnt       = m_cnt + 1;
      nd         = m_dir;
      up_calls   = has_above(m_pend, m_floor);
      down_calls = has_below(m_pend, m_floor);
      go_up      = up_calls && (m_dir || !down_calls);
      case (m_mode)
         M_IDLE: begin
            if (has_bit(m_pend, m_floor) || has_bit(r, m_floor)) nmode = M_DOOR;
            else if (up_calls || down_calls) begin
               nmode = M_MOVE;
               nd    = go_up;
            end
         end
         M_MOVE: begin
            if (m_cnt == MT - 1) begin
               ncnt   = 0;
               nf     = m_dir ? m_floor + 1 : m_floor - 1;
               ahead  = m_dir ? has_above(m_pend, nf) : has_below(m_pend, nf);
               behind = m_dir ? has_below(m_pend, nf) : has_above(m_pend, nf);
               if (has_bit(m_pend, nf)) nmode = M_DOOR;
               else if (!ahead) begin
                  if (behind) nd = !m_dir;
                  else nmode = M_IDLE;
               end
            end
         end
         default: begin
            if (has_bit(r, m_floor)) ncnt = 0;
            else if (m_cnt == DT - 1) begin
               if (up_calls || down_calls) begin
                  nmode = M_MOVE;
                  nd    = go_up;
               end else nmode = M_IDLE;
            end
         end
      endcase
      if (nmode != m_mode) ncnt = 0;
      npend = m_pend | r;
      if (m_mode == M_DOOR || nmode == M_DOOR) npend = npend & ~(32'd1 << nf);
      m_mode  = nmode;
      m_floor = nf;
      m_cnt   = ncnt;
      m_dir   = nd;
      m_pend  = npend;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  = M_IDLE;
         m_floor = 0;
         m_cnt   = 0;
         m_dir   = 1'b1;
         m_pend  = 0;
      end else begin
         model_step(int'(call_req));
      end
   end

   // ---------------- per-cycle compare and door-service logs ----------------
   int   q_main[$];
   int   q16[$];
   int   q2[$];
   logic door_q = 1'b0, d16_q = 1'b0, d2_q = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_cmp",
               {current_floor, pending, dir_up, moving, door_open, idle},
               {4'(m_floor), NF'(m_pend), m_dir, m_mode == M_MOVE, m_mode == M_DOOR, m_mode == M_IDLE});
      end
      if (door_open && !door_q) q_main.push_back(int'(current_floor));
      if (u16_door && !d16_q) q16.push_back(int'(f16));
      if (u2_door && !d2_q) q2.push_back(int'(f2));
      door_q = door_open;
      d16_q  = u16_door;
      d2_q   = u2_door;
   end

   task automatic wait_idle(input string name, input int bound);
      int n;
      n = 0;
      while (!(idle && pending == '0) && n < bound) begin
         step(1);
         n++;
      end
      check(name, n < bound, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #2 rst_n = 1'b0;
      step(2);
      check("reset_floor", current_floor, 0);
      check("reset_pending", pending, 0);
      check("reset_flags", {idle, moving, door_open, dir_up}, 4'b1001);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // single call to floor 3 from floor 0
      call_req = 9'h008;
      step(1);
      call_req = '0;
      check("t1_latch", pending, 9'h008);
      step(11);
      check("t1_floor1", {current_floor, moving}, {4'd1, 1'b1});
      step(10);
      check("t1_floor2", current_floor, 2);
      step(10);
      check("t1_floor3_door", {current_floor, door_open}, {4'd3, 1'b1});
      check("t1_clear_at_entry", pending, 0);
      step(19);
      check("t1_door_last", door_open, 1'b1);
      step(1);
      check("t1_idle", idle, 1'b1);

      // same-floor call while parked, then dwell restart
      call_req = 9'h008;
      step(1);
      call_req = '0;
      check("t3_door_now", {current_floor, door_open}, {4'd3, 1'b1});
      check("t3_no_pending", pending, 0);
      step(10);
      call_req = 9'h008;
      step(1);
      call_req = '0;
      check("t3_still_clear", pending, 0);
      step(19);
      check("t3_restart_open", door_open, 1'b1);
      step(1);
      check("t3_restart_close", idle, 1'b1);

      // reset mid-move, call held across release
      call_req = 9'h080;
      step(1);
      call_req = '0;
      step(15);
      check("t5_midmove", {current_floor, moving}, {4'd4, 1'b1});
      #3 rst_n = 1'b0;
      #1;
      check("t5_async_reset", {current_floor, pending, idle, moving}, {4'd0, 9'h000, 1'b1, 1'b0});
      call_req = 9'h020;
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      call_req = '0;
      check("t5_latch_after_release", pending, 9'h020);
      wait_idle("t5_drain", 300);

      // top floor: open at 8, then reverse to 0
      call_req = 9'h100;
      step(1);
      call_req = '0;
      wait_idle("t4_reach_top", 300);
      check("t4_at_top", {current_floor, dir_up}, {4'd8, 1'b1});
      call_req = 9'h101;
      step(1);
      call_req = '0;
      check("t4_open_top", {current_floor, door_open, pending}, {4'd8, 1'b1, 9'h001});
      step(20);
      check("t4_reverse", {current_floor, moving, dir_up}, {4'd8, 1'b1, 1'b0});
      wait_idle("t4_drain", 300);
      check("t4_bottom", current_floor, 0);

      // calls above and below while travelling up
      q_main.delete();
      call_req = 9'h004;
      step(1);
      call_req = '0;
      step(13);
      call_req = 9'h021;
      step(1);
      call_req = '0;
      wait_idle("t2_drain", 400);
      check("t2_stops", q_main.size(), 3);
      check("t2_stop0", (q_main.size() > 0) ? q_main[0] : -1, 2);
      check("t2_stop1", (q_main.size() > 1) ? q_main[1] : -1, 5);
      check("t2_stop2", (q_main.size() > 2) ? q_main[2] : -1, 0);

      // random traffic against the model
      for (int i = 0; i < 8000; i++) begin
         call_req = ($urandom_range(0, 15) == 0) ? NF'($urandom) : '0;
         step(1);
      end
      call_req = '0;
      wait_idle("rand_drain", 3000);

      // all-ones calls on the 16- and 2-floor builds
      q16.delete();
      q2.delete();
      req16 = '1;
      req2  = '1;
      step(1);
      req16 = '0;
      req2  = '0;
      n = 0;
      while (!(u16_idle && u2_idle && p16 == '0 && p2 == '0) && n < 2000) begin
         step(1);
         n++;
      end
      check("t6_done", n < 2000, 1'b1);
      check("t6_count16", q16.size(), 16);
      for (int i = 0; i < 16; i++) check("t6_order16", (i < q16.size()) ? q16[i] : -1, i);
      check("t6_count2", q2.size(), 2);
      for (int i = 0; i < 2; i++) check("t6_order2", (i < q2.size()) ? q2[i] : -1, i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
